// File: rtl/serial_pattern_checker.sv
// rtl/serial_pattern_checker.sv - serial stream aligner and static/PRBS7 pattern checker
//
// Purpose: samples a recovered serial stream one bit per clock, aligns to it and
//   checks it against either a fixed WIDTH-bit word (static mode) or a PRBS7
//   sequence (dynamic mode). Reports lock, realigned words and a saturating
//   error count for bring-up and self-test.
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   synchronous reset, active high
//   SELDYN     in   dynamic (PRBS7) mode select
//   SELSTAT    in   static mode select
//   signal_in  in   serial stream, one bit per CLK
//   clr_cnt    in   synchronous clear of err_count (wins over an increment)
//   word_out   out  last complete aligned word, MSB = first received bit
//   word_valid out  one-cycle strobe, word_out updated
//   locked     out  high exactly while the checker is in LOCKED
//   bit_err    out  one-cycle strobe, error detected while locked
//   err_count  out  saturating error counter
module serial_pattern_checker #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] STATIC_PAT = 8'hA5,
  parameter int               LOCK_CNT   = 4,
  parameter int               UNLOCK_CNT = 4,
  parameter int               ERR_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SELDYN,
  input  logic             SELSTAT,
  input  logic             signal_in,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             locked,
  output logic             bit_err,
  output logic [ERR_W-1:0] err_count
);

  // Bit counter must reach both WIDTH-1 (word boundary) and 6 (PRBS7 seeding).
  localparam int CW = $clog2((WIDTH > 7) ? WIDTH : 8);
  localparam int GW = $clog2(LOCK_CNT * WIDTH + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);

  localparam logic [CW-1:0]    LAST_BIT   = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    SEED_LAST  = CW'(6);
  localparam logic [GW-1:0]    GOOD_WORDS = GW'(LOCK_CNT);
  localparam logic [GW-1:0]    GOOD_BITS  = GW'(LOCK_CNT * WIDTH);
  localparam logic [BW-1:0]    BAD_WORDS  = BW'(UNLOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  typedef enum logic [1:0] {IDLE, HUNT, VERIFY, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  // Only the WIDTH-1 most recent bits are stored; together with the incoming
  // bit they form the WIDTH-bit shift register contents after this edge.
  logic [WIDTH-2:0]   tail_q, tail_d;
  logic [6:0]         hist_q, hist_d;      // last 7 received bits, [0] newest
  logic [CW-1:0]      bitcnt_q, bitcnt_d;
  logic [GW-1:0]      good_q, good_d;
  logic [BW-1:0]      bad_q, bad_d;
  logic               word_err_q, word_err_d; // current locked word already errored
  logic [WIDTH-1:0]   word_q, word_d;
  logic               word_valid_q, word_valid_d;
  logic               locked_q, locked_d;
  logic               bit_err_q, bit_err_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;

  logic [1:0]         mode;
  logic               dyn, mode_ok, mode_chg;
  logic [WIDTH-1:0]   cur_word;
  logic               pred_ok, at_boundary;
  logic               err_hit, word_bad;

  assign mode        = {SELDYN, SELSTAT};
  assign dyn         = (mode == 2'b10);
  assign mode_ok     = (mode == 2'b10) || (mode == 2'b01);
  assign mode_chg    = (mode != mode_q);
  assign cur_word    = {tail_q, signal_in};
  // PRBS7 x^7+x^6+1: each bit equals the bits 7 and 6 places back XORed.
  assign pred_ok     = (signal_in == (hist_q[6] ^ hist_q[5]));
  assign at_boundary = (bitcnt_q == LAST_BIT);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode;
    tail_d       = tail_q;
    hist_d       = hist_q;
    bitcnt_d     = bitcnt_q + CW'(1);
    good_d       = good_q;
    bad_d        = bad_q;
    word_err_d   = word_err_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    bit_err_d    = 1'b0;
    err_hit      = 1'b0;
    word_bad     = 1'b0;

    if (!mode_ok || mode_chg || (state_q == IDLE)) begin
      // Entering or staying out of a valid mode restarts alignment from scratch;
      // err_count is deliberately left alone.
      state_d    = mode_ok ? HUNT : IDLE;
      tail_d     = '0;
      hist_d     = '0;
      bitcnt_d   = '0;
      good_d     = '0;
      bad_d      = '0;
      word_err_d = 1'b0;
    end else begin
      tail_d = cur_word[WIDTH-2:0];
      hist_d = {hist_q[5:0], signal_in};
      case (state_q)
        HUNT: begin
          if (dyn) begin
            if (bitcnt_q == SEED_LAST) begin
              state_d = VERIFY;
              good_d  = '0;
            end
          end else if (cur_word == STATIC_PAT) begin
            // The hunt match itself counts as the first good word.
            bitcnt_d = '0;
            good_d   = GW'(1);
            state_d  = (GOOD_WORDS <= GW'(1)) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (dyn) begin
            if (!pred_ok) begin
              good_d = '0;
            end else if (good_q + GW'(1) == GOOD_BITS) begin
              state_d  = LOCKED;
              bitcnt_d = '0;
              good_d   = '0;
            end else begin
              good_d = good_q + GW'(1);
            end
          end else if (at_boundary) begin
            bitcnt_d = '0;
            if (cur_word != STATIC_PAT) begin
              state_d = HUNT;
              good_d  = '0;
            end else if (good_q + GW'(1) == GOOD_WORDS) begin
              state_d = LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_q + GW'(1);
            end
          end
        end
        LOCKED: begin
          err_hit    = dyn ? !pred_ok : (at_boundary && (cur_word != STATIC_PAT));
          bit_err_d  = err_hit;
          word_bad   = word_err_q | err_hit;
          word_err_d = word_bad;
          if (at_boundary) begin
            bitcnt_d     = '0;
            word_d       = cur_word;
            word_valid_d = 1'b1;
            word_err_d   = 1'b0;
            if (!word_bad) begin
              bad_d = '0;
            end else if (bad_q + BW'(1) == BAD_WORDS) begin
              state_d = HUNT;
              bad_d   = '0;
              good_d  = '0;
            end else begin
              bad_d = bad_q + BW'(1);
            end
          end
        end
        default: ;
      endcase
    end

    locked_d = (state_d == LOCKED);

    err_count_d = err_count_q;
    if (clr_cnt) begin
      err_count_d = '0;
    end else if (err_hit && (err_count_q != ERR_MAX)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      mode_q       <= '0;
      tail_q       <= '0;
      hist_q       <= '0;
      bitcnt_q     <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      word_err_q   <= 1'b0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      bit_err_q    <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      tail_q       <= tail_d;
      hist_q       <= hist_d;
      bitcnt_q     <= bitcnt_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      word_err_q   <= word_err_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      locked_q     <= locked_d;
      bit_err_q    <= bit_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = word_valid_q;
  assign locked     = locked_q;
  assign bit_err    = bit_err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_serial_pattern_checker.sv
// tb/tb_serial_pattern_checker.sv - self-checking bench for serial_pattern_checker
module tb_serial_pattern_checker;
  localparam int             W       = 8;
  localparam logic [W-1:0]   PAT     = 8'hA5;
  localparam int             LOCKN   = 4;
  localparam int             UNLOCKN = 4;
  localparam int             EW      = 6;
  localparam int             EMAX    = (1 << EW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          SELDYN = 1'b0;
  logic          SELSTAT = 1'b0;
  logic          signal_in = 1'b0;
  logic          clr_cnt = 1'b0;
  logic [W-1:0]  word_out;
  logic          word_valid, locked, bit_err;
  logic [EW-1:0] err_count;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  serial_pattern_checker #(
    .WIDTH(W), .STATIC_PAT(PAT), .LOCK_CNT(LOCKN), .UNLOCK_CNT(UNLOCKN), .ERR_W(EW)
  ) dut (
    .CLK(CLK), .RST(RST), .SELDYN(SELDYN), .SELSTAT(SELSTAT),
    .signal_in(signal_in), .clr_cnt(clr_cnt),
    .word_out(word_out), .word_valid(word_valid), .locked(locked),
    .bit_err(bit_err), .err_count(err_count)
  );

  // Reference model: keeps every bit received since the current mode was
  // entered and derives words/predictions by indexing that record.
  logic         rx[$];
  int           phase = 0;      // 0 idle, 1 hunt, 2 verify, 3 locked
  int           prev_mode = 0;
  int           hunt_from = 0;
  int           anchor = 0;
  int           streak = 0;
  int           bad_words = 0;
  logic         word_has_err = 1'b0;
  logic [W-1:0] e_word = '0;
  logic         e_valid = 1'b0, e_locked = 1'b0, e_err = 1'b0;
  int           e_cnt = 0;

  logic [6:0]   gen;            // bench PRBS7 generator state
  logic [6:0]   sent = '0;      // last 7 bits driven, [0] newest
  int           n_valid = 0, n_err = 0;
  logic         quiet;
  logic [W-1:0] wv;

  function automatic logic bit_at(int j);
    if (j < 0 || j >= rx.size()) return 1'b0;
    return rx[j];
  endfunction

  function automatic logic [W-1:0] window(int k);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) w[i] = bit_at(k - i);
    return w;
  endfunction

  function automatic void enter_lock(int k);
    phase = 3; anchor = k; bad_words = 0; word_has_err = 1'b0;
  endfunction

  function automatic void model_step();
    int mode, k;
    logic good, err_now;
    logic [W-1:0] wrd;
    mode = int'({SELDYN, SELSTAT});
    e_valid = 1'b0;
    err_now = 1'b0;
    if (RST) begin
      phase = 0; prev_mode = 0; rx.delete();
      e_word = '0; e_cnt = 0; e_locked = 1'b0; e_err = 1'b0;
      return;
    end
    if (mode != 1 && mode != 2) begin
      phase = 0; rx.delete();
    end else if (mode != prev_mode || phase == 0) begin
      phase = 1; rx.delete(); hunt_from = 0;
    end else begin
      rx.push_back(signal_in);
      k = rx.size() - 1;
      wrd = window(k);
      good = (signal_in == (bit_at(k - 7) ^ bit_at(k - 6)));
      case (phase)
        1: begin
          if (mode == 2) begin
            if (k - hunt_from == 6) begin phase = 2; streak = 0; end
          end else if (wrd == PAT) begin
            phase = 2; anchor = k; streak = 1;
          end
        end
        2: begin
          if (mode == 2) begin
            streak = good ? streak + 1 : 0;
            if (streak == LOCKN * W) enter_lock(k);
          end else if ((k - anchor) % W == 0) begin
            if (wrd == PAT) begin
              streak++;
              if (streak == LOCKN) enter_lock(k);
            end else begin
              phase = 1; hunt_from = k + 1;
            end
          end
        end
        default: begin
          err_now = (mode == 2) ? !good : (((k - anchor) % W == 0) && wrd != PAT);
          if (err_now) word_has_err = 1'b1;
          if ((k - anchor) % W == 0) begin
            e_word = wrd; e_valid = 1'b1;
            bad_words = word_has_err ? bad_words + 1 : 0;
            word_has_err = 1'b0;
            if (bad_words == UNLOCKN) begin phase = 1; hunt_from = k + 1; end
          end
        end
      endcase
    end
    if (clr_cnt) e_cnt = 0;
    else if (err_now && e_cnt < EMAX) e_cnt++;
    e_err = err_now;
    e_locked = (phase == 3);
    prev_mode = mode;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic b);
    signal_in = b;
    @(posedge CLK);
    model_step();
    sent = {sent[5:0], b};
    #1;
    check("word_out", 32'(word_out), 32'(e_word));
    check("word_valid", 32'(word_valid), 32'(e_valid));
    check("locked", 32'(locked), 32'(e_locked));
    check("bit_err", 32'(bit_err), 32'(e_err));
    check("err_count", 32'(err_count), 32'(e_cnt));
    if (word_valid) n_valid++;
    if (bit_err) n_err++;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) step(w[i]);
  endtask

  task automatic prbs_step(input logic flip);
    logic nb;
    nb = gen[6] ^ gen[5];
    gen = {gen[5:0], nb};
    step(nb ^ flip);
  endtask

  // Continue the stream consistently with whatever was actually sent (good)
  // or force a wrong bit against the same prediction (bad).
  task automatic hist_step(input logic force_err);
    step((sent[6] ^ sent[5]) ^ force_err);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then invalid mode: everything stays quiet.
    RST = 1'b1;
    repeat (3) step(1'($urandom));
    check("reset_locked", 32'(locked), 32'd0);
    RST = 1'b0;
    quiet = 1'b0;
    repeat (50) begin
      step(1'($urandom));
      quiet = quiet | word_valid | locked | bit_err | (|err_count) | (|word_out);
    end
    check("idle_quiet", 32'(quiet), 32'd0);

    // Static mode, A5 stream at a 3-bit offset: lock after the 4th word.
    SELSTAT = 1'b1;
    step(1'($urandom));
    repeat (3) step(1'($urandom));
    wv = PAT;
    repeat (3) send_word(wv);
    for (int i = W - 1; i >= 1; i--) step(wv[i]);
    check("static_prelock", 32'(locked), 32'd0);
    step(wv[0]);
    check("static_lock", 32'(locked), 32'd1);
    n_valid = 0; n_err = 0;
    repeat (6) send_word(wv);
    check("static_valids", 32'(n_valid), 32'd6);
    check("static_word", 32'(word_out), 32'hA5);
    check("static_noerr", 32'(n_err), 32'd0);

    // One corrupted word, then four consecutive bad words.
    send_word(8'hA4);
    check("corrupt_cnt", 32'(err_count), 32'd1);
    check("corrupt_lock", 32'(locked), 32'd1);
    check("corrupt_pulse", 32'(n_err), 32'd1);
    send_word(wv);
    repeat (4) send_word(PAT ^ 8'($urandom_range(1, 255)));
    check("unlock", 32'(locked), 32'd0);
    check("unlock_cnt", 32'(err_count), 32'd5);
    repeat (5) send_word(wv);
    check("relock_static", 32'(locked), 32'd1);

    // Static -> dynamic while locked, then PRBS7 lock after 7+32 bits.
    gen = 7'h7F;
    SELSTAT = 1'b0; SELDYN = 1'b1;
    prbs_step(1'b0);
    check("switch_unlock", 32'(locked), 32'd0);
    check("switch_cnt", 32'(err_count), 32'd5);
    repeat (38) prbs_step(1'b0);
    check("dyn_prelock", 32'(locked), 32'd0);
    prbs_step(1'b0);
    check("dyn_lock", 32'(locked), 32'd1);

    // Three isolated flips: each misses at the flip and 6 and 7 bits later.
    for (int f = 0; f < 3; f++) begin
      repeat ($urandom_range(20, 40)) prbs_step(1'b0);
      prbs_step(1'b1);
    end
    repeat (30) prbs_step(1'b0);
    check("flip_cnt", 32'(err_count), 32'd14);
    check("flip_lock", 32'(locked), 32'd1);

    // Forced error streams drive err_count into saturation.
    repeat (2) begin
      repeat (32) hist_step(1'b1);
      repeat (40) hist_step(1'b0);
    end
    check("saturate", 32'(err_count), 32'(EMAX));
    repeat (8) hist_step(1'b1);
    check("saturate_hold", 32'(err_count), 32'(EMAX));
    repeat (8) hist_step(1'b0);
    clr_cnt = 1'b1;
    hist_step(1'b1);
    clr_cnt = 1'b0;
    check("clr_wins_cnt", 32'(err_count), 32'd0);
    check("clr_wins_err", 32'(bit_err), 32'd1);

    // Reset in the middle of a locked word.
    repeat (5) hist_step(1'b0);
    RST = 1'b1;
    hist_step(1'b0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_word", 32'(word_out), 32'd0);
    RST = 1'b0;
    repeat (45) hist_step(1'b0);
    check("rst_relock", 32'(locked), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
